wb_slave_mem_bridge: RTL and testbench

Parametrised successor to the single-width Wishbone slave front end: a classic-cycle Wishbone slave that bridges to a synchronous word-addressed memory. Adds configurable data/address width, byte selects, a configurable fixed memory read latency, address decode with error termination, and cycle abort. Sits between the processor's Wishbone master and the data memory controller.

---
 rtl/wb_bridge_pkg.sv | 27 ++
 rtl/wb_addr_decode.sv | 31 +++
 rtl/wb_slave_mem_bridge.sv | 140 ++++++++++++++
 tb/tb_wb_slave_mem_bridge.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_bridge_pkg.sv
// Shared types and width helpers for the Wishbone-to-memory bridge family.
package wb_bridge_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StReadWait,
        StResp,
        StErr
    } state_e;

    // Number of byte-offset bits inside one data word.
    function automatic int unsigned off_width(int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

    // Number of bits needed to index DEPTH_WORDS memory words.
    function automatic int unsigned madr_width(int unsigned depth_words);
        return $clog2(depth_words);
    endfunction

    // Latency counter width; must hold the value READ_LAT itself.
    function automatic int unsigned cnt_width(int unsigned read_lat);
        return $clog2(read_lat + 1);
    endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational address decode: window hit, word alignment and word index.
module wb_addr_decode
    import wb_bridge_pkg::*;
#(
    parameter int unsigned          ADDR_W      = 32,
    parameter logic [ADDR_W-1:0]    BASE_ADDR   = '0,
    parameter int unsigned          DEPTH_WORDS = 256,
    parameter int unsigned          SEL_W       = 4,
    localparam int unsigned         MADR_W      = madr_width(DEPTH_WORDS)
) (
    input  logic [ADDR_W-1:0] adr_i,
    output logic              addr_ok_o,
    output logic              align_ok_o,
    output logic [MADR_W-1:0] word_idx_o
);

    localparam int unsigned     OFF_W      = off_width(SEL_W * 8);
    // One extra bit so a window ending exactly at 2^ADDR_W does not wrap.
    localparam logic [ADDR_W:0] SIZE_BYTES = (ADDR_W + 1)'(DEPTH_WORDS * SEL_W);

    logic [ADDR_W-1:0] offset;

    // Range test on the offset from BASE_ADDR, plus alignment and word index.
    always_comb begin
        offset     = adr_i - BASE_ADDR;
        addr_ok_o  = (adr_i >= BASE_ADDR) && ({1'b0, offset} < SIZE_BYTES);
        align_ok_o = (adr_i[OFF_W-1:0] == '0);
        word_idx_o = MADR_W'(offset >> OFF_W);
    end

endmodule

// File: rtl/wb_slave_mem_bridge.sv
// Classic-cycle Wishbone slave bridging to a fixed-latency synchronous memory.
module wb_slave_mem_bridge
    import wb_bridge_pkg::*;
#(
    parameter int unsigned          DATA_W      = 32,
    parameter int unsigned          ADDR_W      = 32,
    parameter logic [ADDR_W-1:0]    BASE_ADDR   = '0,
    parameter int unsigned          DEPTH_WORDS = 256,
    parameter int unsigned          READ_LAT    = 1,
    localparam int unsigned         SEL_W       = DATA_W / 8,
    localparam int unsigned         MADR_W      = madr_width(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cyc_i,
    input  logic              stb_i,
    input  logic              we_i,
    input  logic [SEL_W-1:0]  sel_i,
    input  logic [ADDR_W-1:0] adr_i,
    input  logic [DATA_W-1:0] dat_i,
    output logic [DATA_W-1:0] dat_o,
    output logic              ack_o,
    output logic              err_o,
    output logic [MADR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdat,
    output logic [SEL_W-1:0]  mem_be,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdat
);

    localparam int unsigned      CNT_W    = cnt_width(READ_LAT);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(READ_LAT);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [MADR_W-1:0] madr_q;
    logic [DATA_W-1:0] wdat_q;
    logic [SEL_W-1:0]  be_q;
    logic [DATA_W-1:0] dat_q;

    logic              addr_ok;
    logic              align_ok;
    logic [MADR_W-1:0] word_idx;
    logic              accept;
    logic              capture;

    wb_addr_decode #(
        .ADDR_W      (ADDR_W),
        .BASE_ADDR   (BASE_ADDR),
        .DEPTH_WORDS (DEPTH_WORDS),
        .SEL_W       (SEL_W)
    ) u_addr_decode (
        .adr_i      (adr_i),
        .addr_ok_o  (addr_ok),
        .align_ok_o (align_ok),
        .word_idx_o (word_idx)
    );

    // Next-state, memory strobes and terminations; ack/err are gated by cyc_i for abort.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        capture   = 1'b0;
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        ack_o     = 1'b0;
        err_o     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cyc_i && stb_i) begin
                    accept = 1'b1;
                    cnt_d  = '0;
                    if (!(addr_ok && align_ok)) begin
                        state_d = StErr;
                    end else if (we_i) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StReadWait;
                    end
                end
            end
            StWrite: begin
                // All-zero byte selects are a no-op write that still acks.
                mem_wr_en = |be_q;
                state_d   = cyc_i ? StResp : StIdle;
            end
            StReadWait: begin
                mem_rd_en = (cnt_q == '0);
                if (!cyc_i) begin
                    state_d = StIdle;
                end else if (cnt_q == LAT_LAST) begin
                    capture = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                ack_o   = cyc_i;
                state_d = StIdle;
            end
            StErr: begin
                err_o   = cyc_i;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, latched request fields and read-data register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            madr_q  <= '0;
            wdat_q  <= '0;
            be_q    <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                madr_q <= word_idx;
                wdat_q <= dat_i;
                be_q   <= sel_i;
            end
            if (capture) begin
                dat_q <= mem_rdat;
            end
        end
    end

    assign dat_o    = dat_q;
    assign mem_adr  = madr_q;
    assign mem_wdat = wdat_q;
    assign mem_be   = be_q;

endmodule

// File: tb/tb_wb_slave_mem_bridge.sv
// Bench: two bridges (READ_LAT 1 and 3) with behavioural memories and a response scoreboard.
module tb_wb_slave_mem_bridge;

    typedef struct {
        int          dut;
        bit          is_err;
        bit          is_read;
        logic [31:0] data;
        int          cycle;
    } exp_t;

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        bit          exp_err;
        bit          exp_wr;
        bit          exp_rd;
        logic [3:0]  exp_be;
        logic [7:0]  exp_madr;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        cyc    [2];
    logic        stb    [2];
    logic        we_r   [2];
    logic [3:0]  sel_r  [2];
    logic [31:0] adr_r  [2];
    logic [31:0] dat_r  [2];
    logic [31:0] dat_w      [2];
    logic        ack_w      [2];
    logic        err_w      [2];
    logic [7:0]  mem_adr_w  [2];
    logic [31:0] mem_wdat_w [2];
    logic [3:0]  mem_be_w   [2];
    logic        mem_wr_en_w[2];
    logic        mem_rd_en_w[2];
    logic [31:0] mem_rdat_w [2];

    int          cyc_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        sb_q[$];
    exp_t        mon_e;
    logic        prev_rd [2];
    logic [31:0] ref_mem [2][256];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 1 : 3;
        logic [31:0] mem    [256];
        logic [31:0] pipe_d [LAT];
        logic        pipe_v [LAT];

        wb_slave_mem_bridge #(
            .DATA_W      (32),
            .ADDR_W      (32),
            .BASE_ADDR   (32'h0000_0000),
            .DEPTH_WORDS (256),
            .READ_LAT    (LAT)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .cyc_i     (cyc[g]),
            .stb_i     (stb[g]),
            .we_i      (we_r[g]),
            .sel_i     (sel_r[g]),
            .adr_i     (adr_r[g]),
            .dat_i     (dat_r[g]),
            .dat_o     (dat_w[g]),
            .ack_o     (ack_w[g]),
            .err_o     (err_w[g]),
            .mem_adr   (mem_adr_w[g]),
            .mem_wdat  (mem_wdat_w[g]),
            .mem_be    (mem_be_w[g]),
            .mem_wr_en (mem_wr_en_w[g]),
            .mem_rd_en (mem_rd_en_w[g]),
            .mem_rdat  (mem_rdat_w[g])
        );

        // Memory model: byte-enabled writes, read data valid LAT cycles after mem_rd_en.
        always @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < 256; i++) mem[i] <= '0;
                for (int s = 0; s < LAT; s++) pipe_v[s] <= 1'b0;
            end else begin
                if (mem_wr_en_w[g]) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_be_w[g][b]) mem[mem_adr_w[g]][8*b +: 8] <= mem_wdat_w[g][8*b +: 8];
                end
                pipe_v[0] <= mem_rd_en_w[g];
                pipe_d[0] <= mem[mem_adr_w[g]];
                for (int s = 1; s < LAT; s++) begin
                    pipe_v[s] <= pipe_v[s-1];
                    pipe_d[s] <= pipe_d[s-1];
                end
            end
        end
        assign mem_rdat_w[g] = pipe_v[LAT-1] ? pipe_d[LAT-1] : 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard pop on every termination; also ack/err exclusivity and single-cycle rd strobe.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!reset) begin
                if (ack_w[g] || err_w[g]) begin
                    check("ack_err_exclusive", 64'(ack_w[g] & err_w[g]), 64'd0);
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_term: dut %0d ack %0b err %0b, none expected",
                                 g, ack_w[g], err_w[g]);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("sb_dut", 64'(g), 64'(mon_e.dut));
                        check("sb_is_err", 64'(err_w[g]), 64'(mon_e.is_err));
                        check("sb_cycle", 64'(cyc_cnt), 64'(mon_e.cycle));
                        if (mon_e.is_read) check("sb_rdata", 64'(dat_w[g]), 64'(mon_e.data));
                    end
                end
                if (mem_rd_en_w[g]) check("rd_en_one_cycle", 64'(prev_rd[g]), 64'd0);
                prev_rd[g] = mem_rd_en_w[g];
            end
        end
    end

    task automatic issue(input int g, input bit we, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat);
        exp_t e;
        bit   ok;
        int   lat;
        lat = (g == 0) ? 1 : 3;
        ok  = (adr < 32'h400) && (adr[1:0] == 2'b00);
        cyc[g] = 1'b1; stb[g] = 1'b1; we_r[g] = we;
        sel_r[g] = sel; adr_r[g] = adr; dat_r[g] = dat;
        e.dut     = g;
        e.is_err  = !ok;
        e.is_read = ok && !we;
        e.data    = ok ? ref_mem[g][adr[9:2]] : 32'h0;
        e.cycle   = cyc_cnt + (!ok ? 1 : (we ? 2 : 2 + lat));
        if (ok && we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[g][adr[9:2]][8*b +: 8] = dat[8*b +: 8];
        end
        sb_q.push_back(e);
    endtask

    task automatic wait_done(input int g, input bit release_bus);
        int n;
        n = 0;
        while (!(ack_w[g] || err_w[g]) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL term_timeout: dut %0d no ack/err within 20 cycles", g);
        end
        @(posedge clk); #1;
        if (release_bus) begin
            cyc[g] = 1'b0;
            stb[g] = 1'b0;
        end
    endtask

    task automatic apply_reset(input int ncyc);
        reset = 1'b1;
        for (int g = 0; g < 2; g++) begin
            cyc[g] = 1'b0; stb[g] = 1'b0;
            for (int i = 0; i < 256; i++) ref_mem[g][i] = '0;
        end
        repeat (ncyc) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0004, 4'hF, 32'h0000_00AB, 1'b0, 1'b1, 1'b0, 4'hF, 8'h01};
        vecs[1]  = '{1'b1, 32'h0000_0008, 4'hF, 32'h0000_00AA, 1'b0, 1'b1, 1'b0, 4'hF, 8'h02};
        vecs[2]  = '{1'b0, 32'h0000_0008, 4'h0, 32'h0,         1'b0, 1'b0, 1'b1, 4'h0, 8'h02};
        vecs[3]  = '{1'b0, 32'h0000_0006, 4'hF, 32'h0,         1'b1, 1'b0, 1'b0, 4'h0, 8'h00};
        vecs[4]  = '{1'b0, 32'h0000_0400, 4'hF, 32'h0,         1'b1, 1'b0, 1'b0, 4'h0, 8'h00};
        vecs[5]  = '{1'b1, 32'h0000_0400, 4'hF, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00};
        vecs[6]  = '{1'b1, 32'h0000_000C, 4'h3, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 4'h3, 8'h03};
        vecs[7]  = '{1'b1, 32'h0000_000C, 4'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 4'h0, 8'h03};
        vecs[8]  = '{1'b0, 32'h0000_000C, 4'hF, 32'h0,         1'b0, 1'b0, 1'b1, 4'h0, 8'h03};
        vecs[9]  = '{1'b1, 32'h0000_03FC, 4'hC, 32'hCAFE_0000, 1'b0, 1'b1, 1'b0, 4'hC, 8'hFF};
        vecs[10] = '{1'b0, 32'h0000_03FC, 4'h1, 32'h0,         1'b0, 1'b0, 1'b1, 4'h0, 8'hFF};
        vecs[11] = '{1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0,         1'b1, 1'b0, 1'b0, 4'h0, 8'h00};

        for (int g = 0; g < 2; g++) begin
            we_r[g] = 1'b0; sel_r[g] = '0; adr_r[g] = '0; dat_r[g] = '0; prev_rd[g] = 1'b0;
        end
        apply_reset(3);

        // Reset state of both bridges
        reset = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("rst_dat_o", 64'(dat_w[g]), 64'd0);
            check("rst_ack_err", 64'({ack_w[g], err_w[g]}), 64'd0);
            check("rst_mem_adr", 64'(mem_adr_w[g]), 64'd0);
            check("rst_mem_wdat", 64'(mem_wdat_w[g]), 64'd0);
            check("rst_mem_be", 64'(mem_be_w[g]), 64'd0);
            check("rst_strobes", 64'({mem_wr_en_w[g], mem_rd_en_w[g]}), 64'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;

        // Single transactions on the READ_LAT=1 bridge, strobes checked in cycle 1
        for (int i = 0; i < 12; i++) begin
            issue(0, vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat);
            @(negedge clk);
            @(negedge clk);
            check("v_err_c1", 64'(err_w[0]), 64'(vecs[i].exp_err));
            check("v_wr_en_c1", 64'(mem_wr_en_w[0]), 64'(vecs[i].exp_wr));
            check("v_rd_en_c1", 64'(mem_rd_en_w[0]), 64'(vecs[i].exp_rd));
            if (!vecs[i].exp_err) check("v_mem_adr", 64'(mem_adr_w[0]), 64'(vecs[i].exp_madr));
            if (vecs[i].exp_wr) begin
                check("v_mem_be", 64'(mem_be_w[0]), 64'(vecs[i].exp_be));
                check("v_mem_wdat", 64'(mem_wdat_w[0]), 64'(vecs[i].dat));
            end
            wait_done(0, 1'b1);
        end

        // Back-to-back write then read with stb held across the ack
        issue(0, 1'b1, 32'h0000_0010, 4'hF, 32'h5555_AAAA);
        wait_done(0, 1'b0);
        issue(0, 1'b0, 32'h0000_0010, 4'hF, 32'h0);
        wait_done(0, 1'b1);

        // READ_LAT=3: write 0xAA then read it back, ack in cycle 5
        issue(1, 1'b1, 32'h0000_0008, 4'hF, 32'h0000_00AA);
        wait_done(1, 1'b1);
        issue(1, 1'b0, 32'h0000_0008, 4'hF, 32'h0);
        wait_done(1, 1'b1);
        check("lat3_dat_o", 64'(dat_w[1]), 64'h0000_00AA);

        // Abort a READ_LAT=3 read by dropping cyc in cycle 2
        issue(1, 1'b1, 32'h0000_0020, 4'hF, 32'h0000_0077);
        wait_done(1, 1'b1);
        issue(1, 1'b0, 32'h0000_0020, 4'hF, 32'h0);
        void'(sb_q.pop_back());
        @(posedge clk);
        @(posedge clk); #1;
        cyc[1] = 1'b0; stb[1] = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_dat_hold", 64'(dat_w[1]), 64'h0000_00AA);
        @(posedge clk); #1;
        issue(1, 1'b1, 32'h0000_0024, 4'h6, 32'h00BE_EF00);
        wait_done(1, 1'b1);
        issue(1, 1'b0, 32'h0000_0024, 4'hF, 32'h0);
        wait_done(1, 1'b1);

        // Reset asserted mid READ_WAIT
        issue(1, 1'b0, 32'h0000_0020, 4'hF, 32'h0);
        void'(sb_q.pop_back());
        @(posedge clk);
        @(posedge clk); #1;
        check("pre_rst_in_read", 64'(mem_adr_w[1]), 64'h08);
        apply_reset(1);
        @(negedge clk);
        check("midrst_dat_o", 64'(dat_w[1]), 64'd0);
        check("midrst_ack_err", 64'({ack_w[1], err_w[1]}), 64'd0);
        check("midrst_mem_adr", 64'(mem_adr_w[1]), 64'd0);
        check("midrst_be_wdat", 64'({mem_be_w[1], mem_wdat_w[1]}), 64'd0);
        check("midrst_strobes", 64'({mem_wr_en_w[1], mem_rd_en_w[1]}), 64'd0);
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        issue(1, 1'b1, 32'h0000_0030, 4'hF, 32'hA5A5_0F0F);
        wait_done(1, 1'b1);
        issue(1, 1'b0, 32'h0000_0030, 4'hF, 32'h0);
        wait_done(1, 1'b1);

        repeat (4) @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
